// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared types, constants and width helper for the modular-arithmetic datapath
package mod_arith_pkg;

  localparam int MOD47 = 47;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest w with 2**w >= value.
  function automatic int clog2_mod(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_mul_step.sv
// rtl/mod_mul_step.sv - one MSB-first interleaved step: acc' = (2*acc + bit*a) mod MOD
module mod_mul_step
  import mod_arith_pkg::*;
#(
  parameter int MOD = MOD47,
  parameter int W   = clog2_mod(MOD)
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_a,
  input  logic         i_bit,
  output logic [W-1:0] o_acc
);

  localparam logic [W:0] MOD_V = MOD[W:0];

  logic [W:0] w_dbl;
  logic [W:0] w_red1;
  logic [W:0] w_sum;
  logic [W:0] w_red2;

  assign w_dbl  = {i_acc, 1'b0};
  assign w_red1 = (w_dbl >= MOD_V) ? (w_dbl - MOD_V) : w_dbl;
  assign w_sum  = i_bit ? (w_red1 + {1'b0, i_a}) : w_red1;
  // An out-of-range a still leaves w_red2 below 2**W, so the truncation is safe.
  assign w_red2 = (w_sum >= MOD_V) ? (w_sum - MOD_V) : w_sum;
  assign o_acc  = w_red2[W-1:0];

endmodule

// File: rtl/mod_mul_seq.sv
// rtl/mod_mul_seq.sv - sequential (a*b) mod MOD, one multiplier bit per cycle, valid/ready on both sides
module mod_mul_seq
  import mod_arith_pkg::*;
#(
  parameter int MOD = MOD47,
  parameter int W   = clog2_mod(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         out_err
);

  localparam int         CW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0] MOD_V = MOD[W:0];

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic            r_err;
  logic [W-1:0]    r_r;
  logic            r_out_valid;
  logic            r_out_err;

  logic            w_bit;
  logic [W-1:0]    w_next_acc;

  assign w_bit = r_b[r_cnt];

  mod_mul_step #(.MOD(MOD), .W(W)) u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_bit (w_bit),
    .o_acc (w_next_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_r         <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_err   <= ({1'b0, a} >= MOD_V) || ({1'b0, b} >= MOD_V);
            r_acc   <= '0;
            r_cnt   <= CW'(W - 1);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; afterwards it is held until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_r         <= r_err ? '0 : r_acc;
            r_out_err   <= r_err;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign r         = r_r;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mod_mul_seq.sv
// tb/tb_mod_mul_seq.sv - scoreboard bench for mod_mul_seq at MOD=47 and MOD=7
module tb_mod_mul_seq;

  localparam int W47 = 6;
  localparam int W7  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          in_valid47, in_ready47, out_valid47, out_ready47, out_err47;
  logic [W47-1:0] a47, b47, r47;
  logic          in_valid7, in_ready7, out_valid7, out_ready7, out_err7;
  logic [W7-1:0]  a7, b7, r7;

  mod_mul_seq #(.MOD(47)) dut47 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid47), .in_ready(in_ready47), .a(a47), .b(b47),
    .out_valid(out_valid47), .out_ready(out_ready47), .r(r47), .out_err(out_err47)
  );

  mod_mul_seq #(.MOD(7)) dut7 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid7), .in_ready(in_ready7), .a(a7), .b(b7),
    .out_valid(out_valid7), .out_ready(out_ready7), .r(r7), .out_err(out_err7)
  );

  typedef struct {
    int r;
    int err;
    int t;
  } exp_t;

  exp_t q47[$];
  exp_t q7[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitors: pop the scoreboard on every new result
  logic pv47 = 1'b0;
  always @(negedge clk) begin : mon47
    exp_t e;
    if (out_valid47 && !pv47) begin
      if (q47.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mod47 unexpected result: got r=%0d err=%0d, required no output", r47, out_err47);
      end else begin
        e = q47.pop_front();
        check("mod47 r", int'(r47), e.r);
        check("mod47 out_err", int'(out_err47), e.err);
        check("mod47 latency", cyc - e.t, W47 + 1);
      end
    end
    pv47 <= out_valid47;
  end

  logic pv7 = 1'b0;
  always @(negedge clk) begin : mon7
    exp_t e;
    if (out_valid7 && !pv7) begin
      if (q7.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mod7 unexpected result: got r=%0d err=%0d, required no output", r7, out_err7);
      end else begin
        e = q7.pop_front();
        check("mod7 r", int'(r7), e.r);
        check("mod7 out_err", int'(out_err7), e.err);
        check("mod7 latency", cyc - e.t, W7 + 1);
      end
    end
    pv7 <= out_valid7;
  end

  // sel 0 drives the MOD=47 instance, sel 1 the MOD=7 instance
  task automatic issue(input int sel, input int av, input int bv, input int er, input int ee);
    int   k;
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      a47 = W47'(av); b47 = W47'(bv); in_valid47 = 1'b1;
    end else begin
      a7 = W7'(av); b7 = W7'(bv); in_valid7 = 1'b1;
    end
    k = 0;
    while (!((sel == 0) ? in_ready47 : in_ready7) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL accept timeout sel=%0d a=%0d b=%0d: got in_ready=0, required 1", sel, av, bv);
    end else begin
      @(posedge clk);
      #1;
      e.r = er; e.err = ee; e.t = cyc;
      if (sel == 0) q47.push_back(e);
      else q7.push_back(e);
    end
    in_valid47 = 1'b0;
    in_valid7  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q47.size() != 0 || q7.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard drained", q47.size() + q7.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int k;
    rst = 1'b1;
    in_valid47 = 1'b0; a47 = '0; b47 = '0; out_ready47 = 1'b1;
    in_valid7  = 1'b0; a7  = '0; b7  = '0; out_ready7  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready47", int'(in_ready47), 1);
    check("reset out_valid47", int'(out_valid47), 0);
    check("reset r47", int'(r47), 0);
    check("reset out_err47", int'(out_err47), 0);
    check("reset in_ready7", int'(in_ready7), 1);
    check("reset out_valid7", int'(out_valid7), 0);
    rst = 1'b0;

    issue(0, 5, 7, 35, 0);
    issue(0, 46, 46, 1, 0);
    issue(0, 10, 10, 6, 0);
    issue(0, 0, 33, 0, 0);
    issue(0, 33, 0, 0, 0);
    issue(0, 47, 3, 0, 1);
    issue(0, 2, 3, 6, 0);
    issue(0, 3, 50, 0, 1);
    drain();

    // Backpressure: result must hold and new operands must be ignored
    out_ready47 = 1'b0;
    issue(0, 3, 4, 12, 0);
    k = 0;
    while (!out_valid47 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp out_valid seen", int'(out_valid47), 1);
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid held", int'(out_valid47), 1);
      check("bp r stable", int'(r47), 12);
      check("bp in_ready low", int'(in_ready47), 0);
      a47 = 6'd1; b47 = 6'd1; in_valid47 = 1'b1;
      @(negedge clk);
    end
    in_valid47  = 1'b0;
    out_ready47 = 1'b1;
    @(negedge clk);
    check("bp out_valid drops", int'(out_valid47), 0);
    drain();

    // Reset during RUN cycle 3 drops the operation
    @(negedge clk);
    a47 = 6'd20; b47 = 6'd30; in_valid47 = 1'b1;
    @(negedge clk);
    in_valid47 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst in_ready", int'(in_ready47), 1);
    check("rst out_valid", int'(out_valid47), 0);
    rst = 1'b0;
    issue(0, 9, 9, 34, 0);
    drain();

    issue(1, 6, 6, 1, 0);
    issue(1, 7, 2, 0, 1);
    for (int av = 0; av < 7; av++) begin
      for (int bv = 0; bv < 7; bv++) begin
        issue(1, av, bv, (av * bv) % 7, 0);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
